// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and defaults for the memory access arbiter
package mem_arb_pkg;

    localparam int DEFAULT_DEPTH  = 128;
    localparam int DEFAULT_DATA_W = 8;

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;
    typedef enum logic {SPI, HOST} owner_t;

endpackage

// File: rtl/mem_access_arbiter_if.sv
// rtl/mem_access_arbiter_if.sv - requester handshakes and RAM port of the arbiter
interface mem_access_arbiter_if #(
    parameter int DATA_W = 8,
    parameter int AW     = 7
);
    logic              spiReq;
    logic              spiWrite;
    logic [7:0]        spiAddr;
    logic [DATA_W-1:0] spiWdata;
    logic              spiAck;
    logic              spiErr;

    logic              hostReq;
    logic              hostWrite;
    logic [7:0]        hostAddr;
    logic [DATA_W-1:0] hostWdata;
    logic              hostAck;
    logic              hostErr;

    logic [DATA_W-1:0] rdata;
    logic              busy;

    logic              memEn;
    logic              memWe;
    logic [AW-1:0]     memAddr;
    logic [DATA_W-1:0] memWdata;
    logic [DATA_W-1:0] memRdata;

    modport master (
        output spiReq, spiWrite, spiAddr, spiWdata,
        input  spiAck, spiErr,
        output hostReq, hostWrite, hostAddr, hostWdata,
        input  hostAck, hostErr,
        input  rdata, busy,
        input  memEn, memWe, memAddr, memWdata,
        output memRdata
    );

    modport slave (
        input  spiReq, spiWrite, spiAddr, spiWdata,
        output spiAck, spiErr,
        input  hostReq, hostWrite, hostAddr, hostWdata,
        output hostAck, hostErr,
        output rdata, busy,
        output memEn, memWe, memAddr, memWdata,
        input  memRdata
    );

endinterface

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - combinational two-way round-robin pick
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic   spiReq,
    input  logic   hostReq,
    input  owner_t lastGrant,
    output owner_t winner,
    output logic   anyReq
);

    // On a tie the side that did not win last time goes next.
    always_comb begin
        winner = SPI;
        if (spiReq && hostReq) begin
            winner = (lastGrant == SPI) ? HOST : SPI;
        end else if (hostReq) begin
            winner = HOST;
        end
    end

    assign anyReq = spiReq | hostReq;

endmodule

// File: rtl/mem_access_arbiter.sv
// rtl/mem_access_arbiter.sv - shares a sync-read register RAM between SPI and host
module mem_access_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic clk,
    input  logic reset,
    mem_access_arbiter_if.slave bus
);

    state_t            state;
    owner_t            owner;
    owner_t            last_grant;
    owner_t            winner;
    logic              any_req;
    logic              wr_q;
    logic              oor_q;
    logic              req_write;
    logic [7:0]        req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              req_oor;

    rr_arb2 u_rr_arb2 (
        .spiReq    (bus.spiReq),
        .hostReq   (bus.hostReq),
        .lastGrant (last_grant),
        .winner    (winner),
        .anyReq    (any_req)
    );

    always_comb begin
        req_write = bus.spiWrite;
        req_addr  = bus.spiAddr;
        req_wdata = bus.spiWdata;
        if (winner == HOST) begin
            req_write = bus.hostWrite;
            req_addr  = bus.hostAddr;
            req_wdata = bus.hostWdata;
        end
    end

    assign req_oor = ({24'd0, req_addr} >= 32'(DEPTH));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            owner        <= SPI;
            last_grant   <= HOST;
            wr_q         <= 1'b0;
            oor_q        <= 1'b0;
            bus.busy     <= 1'b0;
            bus.memEn    <= 1'b0;
            bus.memWe    <= 1'b0;
            bus.memAddr  <= '0;
            bus.memWdata <= '0;
            bus.rdata    <= '0;
            bus.spiAck   <= 1'b0;
            bus.spiErr   <= 1'b0;
            bus.hostAck  <= 1'b0;
            bus.hostErr  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // Strobes are registered here so they are clean for the whole ACCESS cycle.
                    if (any_req) begin
                        state        <= ACCESS;
                        owner        <= winner;
                        last_grant   <= winner;
                        wr_q         <= req_write;
                        oor_q        <= req_oor;
                        bus.busy     <= 1'b1;
                        bus.memEn    <= !req_oor;
                        bus.memWe    <= req_write & !req_oor;
                        bus.memAddr  <= req_addr[AW-1:0];
                        bus.memWdata <= req_wdata;
                    end
                end
                ACCESS: begin
                    state     <= WAIT;
                    bus.memEn <= 1'b0;
                    bus.memWe <= 1'b0;
                end
                WAIT: begin
                    state       <= DONE;
                    bus.rdata   <= (!wr_q && !oor_q) ? bus.memRdata : '0;
                    bus.spiAck  <= (owner == SPI);
                    bus.spiErr  <= (owner == SPI) && oor_q;
                    bus.hostAck <= (owner == HOST);
                    bus.hostErr <= (owner == HOST) && oor_q;
                end
                DONE: begin
                    state       <= IDLE;
                    bus.busy    <= 1'b0;
                    bus.spiAck  <= 1'b0;
                    bus.spiErr  <= 1'b0;
                    bus.hostAck <= 1'b0;
                    bus.hostErr <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_arbiter.sv
// tb/tb_mem_access_arbiter.sv - directed self-checking bench for mem_access_arbiter
module tb_mem_access_arbiter;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    int   en_count = 0;
    logic [7:0] mem [0:127];

    mem_access_arbiter_if #(.DATA_W(8), .AW(7)) bus ();

    mem_access_arbiter dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // RAM model: one cycle of read latency
    always @(posedge clk) begin
        if (bus.memEn) begin
            en_count <= en_count + 1;
            if (bus.memWe) mem[bus.memAddr] <= bus.memWdata;
            else           bus.memRdata <= mem[bus.memAddr];
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic set_req(input bit host, input bit wr, input logic [7:0] addr, input logic [7:0] wd);
        if (host) begin
            bus.hostWrite = wr; bus.hostAddr = addr; bus.hostWdata = wd; bus.hostReq = 1'b1;
        end else begin
            bus.spiWrite = wr; bus.spiAddr = addr; bus.spiWdata = wd; bus.spiReq = 1'b1;
        end
    endtask

    task automatic access(input bit host, input bit wr, input logic [7:0] addr, input logic [7:0] wd,
                          input logic [7:0] exp_rd, input bit exp_err, input string tag);
        int lat;
        bit seen;
        set_req(host, wr, addr, wd);
        lat  = 0;
        seen = 0;
        while (!seen && lat < 10) begin
            tick();
            lat++;
            if (host ? bus.hostAck : bus.spiAck) seen = 1;
        end
        chk({tag, "_lat"}, lat, 3);
        chk({tag, "_rdata"}, bus.rdata, exp_rd);
        chk({tag, "_err"}, host ? bus.hostErr : bus.spiErr, exp_err);
        chk({tag, "_other_ack"}, host ? bus.spiAck : bus.hostAck, 0);
        if (host) bus.hostReq = 1'b0; else bus.spiReq = 1'b0;
        tick();
    endtask

    initial begin
        int spi_c, host_c, n, last_c, en_before;
        logic [7:0] a1, a5, r_spi, r_host;

        for (int i = 0; i < 128; i++) mem[i] <= 8'(i + 8'h40);
        rst = 1'b1;
        bus.spiReq = 0; bus.spiWrite = 0; bus.spiAddr = 0; bus.spiWdata = 0;
        bus.hostReq = 0; bus.hostWrite = 0; bus.hostAddr = 0; bus.hostWdata = 0;
        tick();
        chk("rst_busy", bus.busy, 0);
        chk("rst_acks", {bus.spiAck, bus.spiErr, bus.hostAck, bus.hostErr}, 0);
        chk("rst_mem", {bus.memEn, bus.memWe, bus.memAddr, bus.memWdata}, 0);
        chk("rst_rdata", bus.rdata, 0);
        tick();
        rst = 1'b0;
        tick();

        // host write 0x05 <= 0xA5, then read back
        set_req(1, 1, 8'h05, 8'hA5);
        tick();
        chk("wr_memen", bus.memEn, 1);
        chk("wr_memwe", bus.memWe, 1);
        chk("wr_addr", bus.memAddr, 7'h05);
        chk("wr_wdata", bus.memWdata, 8'hA5);
        chk("wr_busy", bus.busy, 1);
        tick();
        chk("wr_wait_memen", bus.memEn, 0);
        tick();
        chk("wr_ack", bus.hostAck, 1);
        chk("wr_err", bus.hostErr, 0);
        bus.hostReq = 1'b0;
        tick();
        chk("wr_idle_busy", bus.busy, 0);
        access(1, 0, 8'h05, 8'h00, 8'hA5, 0, "rd05");

        // simultaneous requests right after reset: SPI first
        reset_dut();
        set_req(0, 0, 8'h10, 8'h00);
        set_req(1, 0, 8'h20, 8'h00);
        spi_c = -1; host_c = -1; a1 = 0; a5 = 0; r_spi = 0; r_host = 0;
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (c == 1) a1 = 8'(bus.memAddr);
            if (c == 5) a5 = 8'(bus.memAddr);
            if (bus.spiAck)  begin spi_c = c;  r_spi = bus.rdata;  bus.spiReq = 1'b0;  end
            if (bus.hostAck) begin host_c = c; r_host = bus.rdata; bus.hostReq = 1'b0; end
        end
        chk("tie_addr_first", a1, 8'h10);
        chk("tie_addr_second", a5, 8'h20);
        chk("tie_spi_ack_cyc", spi_c, 3);
        chk("tie_host_ack_cyc", host_c, 7);
        chk("tie_spi_rdata", r_spi, 8'h50);
        chk("tie_host_rdata", r_host, 8'h60);

        // both sides requesting continuously: strict alternation
        set_req(0, 0, 8'h01, 8'h00);
        set_req(1, 0, 8'h02, 8'h00);
        n = 0; last_c = 0;
        for (int c = 1; c <= 40 && n < 8; c++) begin
            tick();
            if (bus.memEn) chk("rr_busy_access", bus.busy, 1);
            if (bus.spiAck || bus.hostAck) begin
                chk("rr_busy_done", bus.busy, 1);
                chk("rr_side", {bus.spiAck, bus.hostAck}, (n % 2 == 0) ? 2'b10 : 2'b01);
                chk("rr_rdata", bus.rdata, (n % 2 == 0) ? 8'h41 : 8'h42);
                if (n > 0) chk("rr_gap", c - last_c, 4);
                last_c = c;
                n++;
            end
        end
        chk("rr_count", n, 8);
        bus.spiReq = 1'b0; bus.hostReq = 1'b0;
        tick();

        // out-of-range SPI write: no strobe, err flagged
        en_before = en_count;
        access(0, 1, 8'h80, 8'hFF, 8'h00, 1, "oor");
        chk("oor_no_memen", en_count, en_before);
        access(0, 0, 8'h00, 8'h00, 8'h40, 0, "rd00");

        // reset in WAIT of a host read, request kept high
        set_req(1, 0, 8'h05, 8'h00);
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("mid_rst_outs", {bus.busy, bus.memEn, bus.memWe, bus.spiAck, bus.hostAck, bus.hostErr}, 0);
        chk("mid_rst_data", {bus.rdata, bus.memAddr, bus.memWdata}, 0);
        tick();
        chk("mid_rst_noack", bus.hostAck, 0);
        rst = 1'b0;
        n = 0;
        while (!bus.hostAck && n < 10) begin
            tick();
            n++;
        end
        chk("post_rst_lat", n, 3);
        chk("post_rst_rdata", bus.rdata, 8'hA5);
        bus.hostReq = 1'b0;
        tick();

        // host reads top address; SPI arrives mid-access
        set_req(1, 0, 8'h7F, 8'h00);
        tick();
        set_req(0, 0, 8'h03, 8'h00);
        spi_c = -1; host_c = -1; a5 = 0; r_spi = 0; r_host = 8'h00;
        for (int c = 2; c <= 10; c++) begin
            tick();
            if (c == 5) a5 = 8'(bus.memAddr);
            if (bus.hostAck) begin host_c = c; r_host = bus.rdata; chk("top_err", bus.hostErr, 0); bus.hostReq = 1'b0; end
            if (bus.spiAck)  begin spi_c = c;  r_spi = bus.rdata;  bus.spiReq = 1'b0;  end
        end
        chk("top_host_ack_cyc", host_c, 3);
        chk("top_host_rdata", r_host, 8'hBF);
        chk("top_spi_addr", a5, 8'h03);
        chk("top_spi_ack_cyc", spi_c, 7);
        chk("top_spi_rdata", r_spi, 8'h43);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
